spi_shifter: RTL and testbench

- Serial data path of the SPI controller; sits directly downstream of the baud rate generator.
- Uses the generator's edge-flag pulses to drive MOSI and to sample MISO, one bit per SCLK edge pair.
- Serialises a DATA_W-bit word from the APB slave interface and deserialises the received word back to it.
- Supports all four CPOL/CPHA modes, MSB-first and LSB-first order, and abort on slave-select release.

---
 rtl/spi_shifter.sv | 121 ++++++++++++
 tb/tb_spi_shifter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shifter.sv
// spi_shifter: SPI serial data path; shifts mosi and samples miso on baud-generator edge flags.
// Optional `SPI_SHIFTER_LOOPBACK_EN adds a loopback input that feeds mosi back to the sampler.
module spi_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              PClk,
  input  logic              PRESETn,
  input  logic              ss,
  input  logic              send_data,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              lsbfe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              flag_low,
  input  logic              flags_low,
  input  logic              flag_high,
  input  logic              flags_high,
  input  logic              miso,
`ifdef SPI_SHIFTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              rx_valid,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic              state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic              lsbfe_q;
  logic              cpha_q;
  logic              cpol_q;
  logic              mode_sel;
  logic              shift_evt;
  logic              sample_evt;
  logic              sample_bit;
  logic [DATA_W-1:0] rx_next;

  // Handshake: send_data is a load strobe taken only while busy=0 (no stall path);
  // rx_valid is a one-cycle pulse with data_miso, and the consumer cannot back-pressure it.

  assign mode_sel   = cpha_q ^ cpol_q;
  assign shift_evt  = (state == ST_ACTIVE) && (mode_sel ? flags_low : flags_high);
  assign sample_evt = (state == ST_ACTIVE) && (mode_sel ? flag_high : flag_low);
  assign busy       = (state == ST_ACTIVE);

`ifdef SPI_SHIFTER_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  assign rx_next = lsbfe_q ? {sample_bit, rx_sr[DATA_W-1:1]}
                           : {rx_sr[DATA_W-2:0], sample_bit};

  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      mosi      <= 1'b0;
      data_miso <= '0;
      rx_valid  <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      lsbfe_q   <= 1'b0;
      cpha_q    <= 1'b0;
      cpol_q    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (send_data) begin
          lsbfe_q <= lsbfe;
          cpha_q  <= cpha;
          cpol_q  <= cpol;
          rx_sr   <= '0;
          rx_cnt  <= '0;
          state   <= ST_ACTIVE;
          // With cpha=0 the first bit must already sit on mosi before the first sampling edge.
          if (cpha) begin
            tx_sr  <= data_mosi;
            tx_cnt <= '0;
          end else begin
            mosi   <= lsbfe ? data_mosi[0] : data_mosi[DATA_W-1];
            tx_sr  <= lsbfe ? (data_mosi >> 1) : (data_mosi << 1);
            tx_cnt <= CNT_W'(1);
          end
        end
      end else if (ss) begin
        // Slave select released: drop the partial word, keep data_miso and mosi as they are.
        state <= ST_IDLE;
      end else begin
        if (shift_evt && (tx_cnt < CNT_FULL)) begin
          mosi   <= lsbfe_q ? tx_sr[0] : tx_sr[DATA_W-1];
          tx_sr  <= lsbfe_q ? (tx_sr >> 1) : (tx_sr << 1);
          tx_cnt <= tx_cnt + 1'b1;
        end
        if (sample_evt) begin
          rx_sr  <= rx_next;
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == CNT_LAST) begin
            data_miso <= rx_next;
            rx_valid  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_shifter.sv
// tb_spi_shifter: table-driven bench for spi_shifter with an emulated baud generator and SPI slave.
module tb_spi_shifter;

  localparam int DW = 8;

  logic          PClk = 1'b0;
  logic          PRESETn;
  logic          ss;
  logic          send_data;
  logic [DW-1:0] data_mosi;
  logic          lsbfe;
  logic          cpol;
  logic          cpha;
  logic          flag_low;
  logic          flags_low;
  logic          flag_high;
  logic          flags_high;
  logic          miso;
  logic          mosi;
  logic [DW-1:0] data_miso;
  logic          rx_valid;
  logic          busy;
`ifdef SPI_SHIFTER_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif

  spi_shifter #(.DATA_W(DW)) dut (
    .PClk       (PClk),
    .PRESETn    (PRESETn),
    .ss         (ss),
    .send_data  (send_data),
    .data_mosi  (data_mosi),
    .lsbfe      (lsbfe),
    .cpol       (cpol),
    .cpha       (cpha),
    .flag_low   (flag_low),
    .flags_low  (flags_low),
    .flag_high  (flag_high),
    .flags_high (flags_high),
    .miso       (miso),
`ifdef SPI_SHIFTER_LOOPBACK_EN
    .loopback   (loopback),
`endif
    .mosi       (mosi),
    .data_miso  (data_miso),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 PClk = ~PClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          lsbfe;
    logic          cpol;
    logic          cpha;
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } vec_t;

  logic [DW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          hold_mosi;
  logic [DW-1:0] last_rx;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge PClk) begin
    if (PRESETn === 1'b1 && rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_valid_unexpected: got pulse with data_miso %h, required none", data_miso);
      end else begin
        chkw("data_miso", data_miso, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic bit_at(input logic [DW-1:0] w, input logic lsb, input int k);
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  task automatic tick();
    @(negedge PClk);
  endtask

  // One generator pulse: level of SCLK (high/low) and early ("toggling next cycle") or late.
  task automatic pulse(input logic lvl_high, input logic early);
    flags_low  = !lvl_high && early;
    flag_low   = !lvl_high && !early;
    flags_high = lvl_high && early;
    flag_high  = lvl_high && !early;
    tick();
    {flag_low, flags_low, flag_high, flags_high} = 4'b0;
  endtask

  task automatic start_xfer(input vec_t v);
    lsbfe     = v.lsbfe;
    cpol      = v.cpol;
    cpha      = v.cpha;
    data_mosi = v.tx;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
    data_mosi = ~v.tx;
    lsbfe     = ~v.lsbfe;
    cpha      = ~v.cpha;
    cpol      = ~v.cpol;
    chk1("busy_start", busy, 1'b1);
    if (v.cpha) begin
      chk1("mosi_hold_cpha1", mosi, hold_mosi);
      tick();
      chk1("mosi_hold_cpha1_idle", mosi, hold_mosi);
    end else begin
      chk1("mosi_first_bit", mosi, bit_at(v.tx, v.lsbfe, 0));
    end
  endtask

  // Emulated generator + slave for bits k0..k1; the last trailing half-period is omitted
  // when the final sample falls on the leading edge.
  task automatic run_bits(input vec_t v, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      miso = bit_at(v.rx, v.lsbfe, k);
      pulse(v.cpol, 1'b1);
      if (!v.cpha) chk1($sformatf("mosi_bit%0d", k), mosi, bit_at(v.tx, v.lsbfe, k));
      pulse(v.cpol, 1'b0);
      if (v.cpha || k != DW-1) begin
        pulse(!v.cpol, 1'b1);
        if (v.cpha) chk1($sformatf("mosi_bit%0d", k), mosi, bit_at(v.tx, v.lsbfe, k));
        pulse(!v.cpol, 1'b0);
      end
    end
  endtask

  task automatic full_xfer(input vec_t v, input bit chain, input int ign_at);
    exp_q.push_back(v.rx);
    last_rx = v.rx;
    start_xfer(v);
    if (ign_at > 0) begin
      run_bits(v, 0, ign_at - 1);
      data_mosi = '1;
      send_data = 1'b1;
      tick();
      send_data = 1'b0;
      chk1("busy_ignore_send", busy, 1'b1);
      run_bits(v, ign_at, DW-1);
    end else begin
      run_bits(v, 0, DW-1);
    end
    chk1("busy_done", busy, 1'b0);
    chk1("rx_valid_pulse", rx_valid, 1'b1);
    hold_mosi = bit_at(v.tx, v.lsbfe, DW-1);
    if (!chain) begin
      tick();
      chk1("rx_valid_single", rx_valid, 1'b0);
      chk1("mosi_idle_hold", mosi, hold_mosi);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[8];
  vec_t v;

  initial begin
    PRESETn = 1'b0;
    ss = 1'b0; send_data = 1'b0; data_mosi = '0;
    lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
    {flag_low, flags_low, flag_high, flags_high} = 4'b0;
    hold_mosi = 1'b0;
    last_rx   = '0;

    vecs[0] = '{lsbfe: 1'b0, cpol: 1'b0, cpha: 1'b0, tx: 8'hC1, rx: 8'h3C};
    vecs[1] = '{lsbfe: 1'b0, cpol: 1'b0, cpha: 1'b1, tx: 8'h5A, rx: 8'hA5};
    vecs[2] = '{lsbfe: 1'b0, cpol: 1'b1, cpha: 1'b0, tx: 8'h3D, rx: 8'h81};
    vecs[3] = '{lsbfe: 1'b1, cpol: 1'b1, cpha: 1'b1, tx: 8'h6E, rx: 8'h17};
    vecs[4] = '{lsbfe: 1'b1, cpol: 1'b0, cpha: 1'b1, tx: 8'h2B, rx: 8'hD4};
    for (int i = 5; i < 7; i++) begin
      vecs[i].lsbfe = 1'($urandom_range(0, 1));
      vecs[i].cpol  = 1'($urandom_range(0, 1));
      vecs[i].cpha  = 1'($urandom_range(0, 1));
      vecs[i].tx    = DW'($urandom_range(0, 255));
      vecs[i].rx    = DW'($urandom_range(0, 255));
    end
    vecs[7] = '{lsbfe: 1'b1, cpol: 1'b0, cpha: 1'b0, tx: 8'hC1, rx: 8'h96};

    tick(); tick();
    chk1("reset_mosi", mosi, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_rx_valid", rx_valid, 1'b0);
    chkw("reset_data_miso", data_miso, '0);
    PRESETn = 1'b1;
    tick();
    pulse(1'b0, 1'b0);
    chk1("idle_busy_flags", busy, 1'b0);

    for (int i = 0; i < 8; i++) full_xfer(vecs[i], 1'b0, -1);

    // Abort after three samples: partial word dropped, previous word kept.
    v = '{lsbfe: 1'b0, cpol: 1'b0, cpha: 1'b0, tx: 8'hE4, rx: 8'h5B};
    start_xfer(v);
    run_bits(v, 0, 2);
    ss = 1'b1;
    tick();
    ss = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_rx_valid", rx_valid, 1'b0);
    chkw("abort_data_miso", data_miso, 8'h96);
    chk1("abort_mosi_hold", mosi, bit_at(v.tx, v.lsbfe, 3));
    hold_mosi = bit_at(v.tx, v.lsbfe, 3);
    for (int i = 0; i < 4; i++) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk1("abort_idle_busy", busy, 1'b0);

    // Mid-transfer send_data ignored, then a back-to-back word with no gap cycle.
    v = '{lsbfe: 1'b0, cpol: 1'b0, cpha: 1'b0, tx: 8'hA7, rx: 8'h4E};
    full_xfer(v, 1'b1, 3);
    v = '{lsbfe: 1'b1, cpol: 1'b1, cpha: 1'b1, tx: 8'h00, rx: 8'hC3};
    full_xfer(v, 1'b0, -1);

    // Asynchronous reset in the middle of a transfer.
    v = '{lsbfe: 1'b0, cpol: 1'b0, cpha: 1'b0, tx: 8'h81, rx: 8'h7E};
    start_xfer(v);
    run_bits(v, 0, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk1("async_rst_mosi", mosi, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_rx_valid", rx_valid, 1'b0);
    chkw("async_rst_data_miso", data_miso, '0);
    tick();
    PRESETn = 1'b1;
    hold_mosi = 1'b0;
    last_rx   = '0;
    for (int k = 0; k < 6; k++) pulse(k[0], k[1]);
    chk1("post_rst_busy", busy, 1'b0);
    chk1("post_rst_mosi", mosi, 1'b0);

    v = '{lsbfe: 1'b0, cpol: 1'b1, cpha: 1'b1, tx: 8'h69, rx: 8'hB2};
    full_xfer(v, 1'b0, -1);

    tick(); tick();
    chkw("rx_pending", DW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
